decode_stage: RTL and testbench

//  ID stage of the RV32I pipeline core, between the IF/ID register and EX.

---
 rtl/decode_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: control/immediate decode, WB->ID write-through bypass,
// and the ID/EX pipeline register with synchronous reset, flush and stall.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic            valid_d,
  input  logic            stall_d,
  input  logic            flush_e,
  output logic [4:0]      a1_d,
  output logic [4:0]      a2_d,
  input  logic [XLEN-1:0] rd1_rf,
  input  logic [XLEN-1:0] rd2_rf,
  input  logic            we_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic            valid_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            alu_src_e,
  output logic [1:0]      result_src_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic [2:0]      alu_ctrl_e,
  output logic            illegal_e
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Returns {unsupported, alu_ctrl} for the funct3-selected ALU operations.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic is_sub);
    case (f3)
      3'b000:  alu_from_funct = {1'b0, (is_sub ? ALU_SUB : ALU_ADD)};
      3'b010:  alu_from_funct = {1'b0, ALU_SLT};
      3'b100:  alu_from_funct = {1'b0, ALU_XOR};
      3'b110:  alu_from_funct = {1'b0, ALU_OR};
      3'b111:  alu_from_funct = {1'b0, ALU_AND};
      default: alu_from_funct = {1'b1, ALU_ADD};
    endcase
  endfunction

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [3:0]      w_fn;
  logic [XLEN-1:0] w_imm;
  logic            w_reg_write;
  logic            w_mem_write;
  logic            w_alu_src;
  logic [1:0]      w_result_src;
  logic            w_branch;
  logic            w_jump;
  logic [2:0]      w_alu_ctrl;
  logic            w_illegal;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  logic            r_valid;
  logic [XLEN-1:0] r_rd1;
  logic [XLEN-1:0] r_rd2;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_reg_write;
  logic            r_mem_write;
  logic            r_alu_src;
  logic [1:0]      r_result_src;
  logic            r_branch;
  logic            r_jump;
  logic [2:0]      r_alu_ctrl;
  logic            r_illegal;

  assign a1_d     = instr_d[19:15];
  assign a2_d     = instr_d[24:20];
  assign w_opcode = instr_d[6:0];
  assign w_funct3 = instr_d[14:12];
  // Only R-type honours funct7[5]; for I-ALU that bit is part of the immediate.
  assign w_fn     = alu_from_funct(w_funct3, (w_opcode == OP_R) && instr_d[30]);

  always_comb begin
    w_imm        = '0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_result_src = 2'b00;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alu_ctrl   = ALU_ADD;
    w_illegal    = 1'b0;
    case (w_opcode)
      OP_LW: begin
        w_imm        = {{20{instr_d[31]}}, instr_d[31:20]};
        w_alu_src    = 1'b1;
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      OP_SW: begin
        w_imm       = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      OP_R: begin
        w_reg_write = 1'b1;
        w_alu_ctrl  = w_fn[2:0];
        w_illegal   = w_fn[3];
      end
      OP_I: begin
        w_imm       = {{20{instr_d[31]}}, instr_d[31:20]};
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_ctrl  = w_fn[2:0];
        w_illegal   = w_fn[3];
      end
      OP_BEQ: begin
        w_imm      = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
        w_branch   = 1'b1;
        w_alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        w_imm        = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
        w_jump       = 1'b1;
        w_reg_write  = 1'b1;
        w_result_src = 2'b10;
      end
      default: w_illegal = 1'b1;
    endcase
    // Bubbles and unsupported encodings must not cause any architectural side effect.
    if (w_illegal || !valid_d) begin
      w_reg_write  = 1'b0;
      w_mem_write  = 1'b0;
      w_alu_src    = 1'b0;
      w_result_src = 2'b00;
      w_branch     = 1'b0;
      w_jump       = 1'b0;
      w_alu_ctrl   = ALU_ADD;
    end
    if (!valid_d) w_illegal = 1'b0;
  end

  // Register file writes on the same edge, so forward the WB value; x0 is hard-wired.
  assign w_rd1 = (we_w && (rd_w != 5'd0) && (rd_w == a1_d)) ? result_w : rd1_rf;
  assign w_rd2 = (we_w && (rd_w != 5'd0) && (rd_w == a2_d)) ? result_w : rd2_rf;

  // ID/EX boundary
  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      r_valid      <= 1'b0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_pc         <= '0;
      r_pc_plus4   <= '0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_result_src <= 2'b00;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_alu_ctrl   <= 3'b000;
      r_illegal    <= 1'b0;
    end else if (!stall_d) begin
      r_valid      <= valid_d;
      r_rd1        <= w_rd1;
      r_rd2        <= w_rd2;
      r_imm        <= w_imm;
      r_rs1        <= instr_d[19:15];
      r_rs2        <= instr_d[24:20];
      r_rd         <= instr_d[11:7];
      r_pc         <= pc_d;
      r_pc_plus4   <= pc_plus4_d;
      r_reg_write  <= w_reg_write;
      r_mem_write  <= w_mem_write;
      r_alu_src    <= w_alu_src;
      r_result_src <= w_result_src;
      r_branch     <= w_branch;
      r_jump       <= w_jump;
      r_alu_ctrl   <= w_alu_ctrl;
      r_illegal    <= w_illegal;
    end
  end

  assign valid_e      = r_valid;
  assign rd1_e        = r_rd1;
  assign rd2_e        = r_rd2;
  assign imm_e        = r_imm;
  assign rs1_e        = r_rs1;
  assign rs2_e        = r_rs2;
  assign rd_e         = r_rd;
  assign pc_e         = r_pc;
  assign pc_plus4_e   = r_pc_plus4;
  assign reg_write_e  = r_reg_write;
  assign mem_write_e  = r_mem_write;
  assign alu_src_e    = r_alu_src;
  assign result_src_e = r_result_src;
  assign branch_e     = r_branch;
  assign jump_e       = r_jump;
  assign alu_ctrl_e   = r_alu_ctrl;
  assign illegal_e    = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic checked against
// an arithmetic reference model of the decode rules and ID/EX register behaviour.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d, stall_d, flush_e;
  logic [4:0]  a1_d, a2_d;
  logic [31:0] rd1_rf, rd2_rf;
  logic        we_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        valid_e;
  logic [31:0] rd1_e, rd2_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] pc_e, pc_plus4_e;
  logic        reg_write_e, mem_write_e, alu_src_e;
  logic [1:0]  result_src_e;
  logic        branch_e, jump_e;
  logic [2:0]  alu_ctrl_e;
  logic        illegal_e;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    logic [1:0]  result_src;
    logic        branch;
    logic        jump;
    logic [2:0]  alu_ctrl;
    logic        illegal;
  } out_t;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .stall_d(stall_d), .flush_e(flush_e), .a1_d(a1_d), .a2_d(a2_d),
    .rd1_rf(rd1_rf), .rd2_rf(rd2_rf), .we_w(we_w), .rd_w(rd_w), .result_w(result_w),
    .valid_e(valid_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .rd_e(rd_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .alu_src_e(alu_src_e),
    .result_src_e(result_src_e), .branch_e(branch_e), .jump_e(jump_e),
    .alu_ctrl_e(alu_ctrl_e), .illegal_e(illegal_e)
  );

  always #5 clk = ~clk;

  function automatic out_t get_obs();
    out_t o;
    o = '{valid_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e,
          reg_write_e, mem_write_e, alu_src_e, result_src_e, branch_e, jump_e,
          alu_ctrl_e, illegal_e};
    return o;
  endfunction

  // Reference: expected ID/EX contents after loading, plus the mask of fields the rules define.
  function automatic void model(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4,
                                input logic v, input logic [31:0] r1, input logic [31:0] r2,
                                input logic we, input logic [4:0] rdw, input logic [31:0] res,
                                output out_t e, output out_t m);
    int imm;
    bit has_imm, legal, rw, mw, asrc, br, jp;
    logic [1:0] rsrc;
    logic [2:0] ac;
    e = '0; m = '0;
    imm = 0; has_imm = 1; legal = 1; rw = 0; mw = 0; asrc = 0; br = 0; jp = 0;
    rsrc = 2'd0; ac = 3'd0;
    case (ins[6:0])
      7'h03: begin imm = int'($signed(ins[31:20])); asrc = 1; rsrc = 2'd1; rw = 1; end
      7'h23: begin imm = int'($signed({ins[31:25], ins[11:7]})); asrc = 1; mw = 1; end
      7'h33, 7'h13: begin
        if (ins[6:0] == 7'h13) begin imm = int'($signed(ins[31:20])); asrc = 1; end
        else has_imm = 0;
        rw = 1;
        case (ins[14:12])
          3'd0: ac = (ins[6:0] == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
          3'd2: ac = 3'd5;
          3'd4: ac = 3'd4;
          3'd6: ac = 3'd3;
          3'd7: ac = 3'd2;
          default: legal = 0;
        endcase
      end
      7'h63: begin
        imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        br = 1; ac = 3'd1;
      end
      7'h6F: begin
        imm = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
              + int'(ins[30:21]) * 2;
        jp = 1; rw = 1; rsrc = 2'd2;
      end
      default: begin legal = 0; has_imm = 0; end
    endcase
    e.valid = v;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.pc = pc; e.pc4 = pc4;
    e.rd1 = (we && rdw != 0 && rdw == ins[19:15]) ? res : r1;
    e.rd2 = (we && rdw != 0 && rdw == ins[24:20]) ? res : r2;
    e.imm = imm;
    e.illegal = v && !legal;
    if (v && legal) begin
      e.reg_write = rw; e.mem_write = mw; e.alu_src = asrc; e.result_src = rsrc;
      e.branch = br; e.jump = jp; e.alu_ctrl = ac;
    end
    m.valid = '1; m.reg_write = '1; m.mem_write = '1; m.branch = '1; m.jump = '1;
    if (v) begin
      m.illegal = '1; m.rd1 = '1; m.rd2 = '1; m.rs1 = '1; m.rs2 = '1; m.rd = '1;
      m.pc = '1; m.pc4 = '1;
      if (has_imm) m.imm = '1;
      if (legal) begin m.alu_src = '1; m.result_src = '1; m.alu_ctrl = '1; end
    end
  endfunction

  task automatic idle_inputs();
    instr_d = 32'h0; pc_d = 32'h0; pc_plus4_d = 32'h4; valid_d = 1'b0;
    stall_d = 1'b0; flush_e = 1'b0; rd1_rf = 32'h0; rd2_rf = 32'h0;
    we_w = 1'b0; rd_w = 5'd0; result_w = 32'h0;
  endtask

  task automatic test_reset();
    out_t o;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instr_d = $urandom; pc_d = $urandom; pc_plus4_d = $urandom; valid_d = 1'($urandom);
      stall_d = 1'($urandom); flush_e = 1'b0; rd1_rf = $urandom; rd2_rf = $urandom;
      we_w = 1'($urandom); rd_w = 5'($urandom); result_w = $urandom;
      @(posedge clk); #1;
      o = get_obs();
      vectors++;
      if (o !== out_t'(0)) begin
        errors++; $display("FAIL reset_state cycle %0d: got %h want 0", i, o);
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_addi();
    idle_inputs();
    instr_d = 32'hFFD00293; valid_d = 1'b1; rd1_rf = 32'h0;
    @(posedge clk); #1;
    vectors++;
    if (rd1_e !== 32'h0 || imm_e !== 32'hFFFFFFFD || alu_ctrl_e !== 3'b000 ||
        alu_src_e !== 1'b1 || reg_write_e !== 1'b1 || rd_e !== 5'd5 || valid_e !== 1'b1) begin
      errors++;
      $display("FAIL addi: rd1=%h imm=%h alu=%b src=%b rw=%b rd=%0d v=%b want 0 fffffffd 000 1 1 5 1",
               rd1_e, imm_e, alu_ctrl_e, alu_src_e, reg_write_e, rd_e, valid_e);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    instr_d = 32'h002081B3; valid_d = 1'b1; rd1_rf = 32'hDEAD; rd2_rf = 32'hBEEF;
    we_w = 1'b1; rd_w = 5'd1; result_w = 32'h1234;
    #1;
    vectors++;
    if (a1_d !== 5'd1 || a2_d !== 5'd2) begin
      errors++; $display("FAIL read_addr: a1=%0d a2=%0d want 1 2", a1_d, a2_d);
    end
    @(posedge clk); #1;
    vectors++;
    if (rd1_e !== 32'h1234 || rd2_e !== 32'hBEEF || alu_ctrl_e !== 3'b000) begin
      errors++; $display("FAIL bypass_rs1: rd1=%h rd2=%h alu=%b want 1234 beef 000", rd1_e, rd2_e, alu_ctrl_e);
    end
    rd_w = 5'd0;
    @(posedge clk); #1;
    vectors++;
    if (rd1_e !== 32'hDEAD || rd2_e !== 32'hBEEF) begin
      errors++; $display("FAIL no_bypass_rd0: rd1=%h rd2=%h want dead beef", rd1_e, rd2_e);
    end
    rd_w = 5'd2;
    @(posedge clk); #1;
    vectors++;
    if (rd1_e !== 32'hDEAD || rd2_e !== 32'h1234) begin
      errors++; $display("FAIL bypass_rs2: rd1=%h rd2=%h want dead 1234", rd1_e, rd2_e);
    end
    instr_d = 32'h00200133; rd_w = 5'd0; rd1_rf = 32'h0;  // add x2,x0,x2 with WB to x0
    @(posedge clk); #1;
    vectors++;
    if (rd1_e !== 32'h0) begin
      errors++; $display("FAIL x0_never_bypassed: rd1=%h want 0", rd1_e);
    end
  endtask

  task automatic test_sub_beq();
    idle_inputs();
    instr_d = 32'h402081B3; valid_d = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (alu_ctrl_e !== 3'b001 || reg_write_e !== 1'b1 || illegal_e !== 1'b0) begin
      errors++; $display("FAIL sub: alu=%b rw=%b ill=%b want 001 1 0", alu_ctrl_e, reg_write_e, illegal_e);
    end
    instr_d = 32'hFE208CE3;  // beq x1,x2,-8
    @(posedge clk); #1;
    vectors++;
    if (branch_e !== 1'b1 || imm_e !== 32'hFFFFFFF8 || alu_ctrl_e !== 3'b001 ||
        reg_write_e !== 1'b0 || jump_e !== 1'b0) begin
      errors++; $display("FAIL beq: br=%b imm=%h alu=%b rw=%b j=%b want 1 fffffff8 001 0 0",
                         branch_e, imm_e, alu_ctrl_e, reg_write_e, jump_e);
    end
  endtask

  task automatic test_stall_flush();
    out_t held;
    idle_inputs();
    instr_d = 32'h0020A423; valid_d = 1'b1; pc_d = 32'h100; pc_plus4_d = 32'h104;  // sw x2,8(x1)
    @(posedge clk); #1;
    vectors++;
    if (mem_write_e !== 1'b1 || imm_e !== 32'd8 || reg_write_e !== 1'b0 || pc_e !== 32'h100) begin
      errors++; $display("FAIL sw_load: mw=%b imm=%h rw=%b pc=%h want 1 8 0 100", mem_write_e, imm_e, reg_write_e, pc_e);
    end
    held = get_obs();
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_d = 32'h002081B3; pc_d = $urandom; rd1_rf = $urandom;
      we_w = 1'b1; rd_w = 5'd1; result_w = $urandom;
      @(posedge clk); #1;
      vectors++;
      if (get_obs() !== held) begin
        errors++; $display("FAIL stall_hold cycle %0d: got %h want %h", i, get_obs(), held);
      end
    end
    flush_e = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (valid_e !== 1'b0 || mem_write_e !== 1'b0 || get_obs() !== out_t'(0)) begin
      errors++; $display("FAIL flush_over_stall: got %h want 0", get_obs());
    end
    idle_inputs();
  endtask

  task automatic test_illegal();
    idle_inputs();
    instr_d = 32'h0000007F; valid_d = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (illegal_e !== 1'b1 || valid_e !== 1'b1 || reg_write_e !== 1'b0 || mem_write_e !== 1'b0) begin
      errors++; $display("FAIL illegal_opcode: ill=%b v=%b rw=%b mw=%b want 1 1 0 0",
                         illegal_e, valid_e, reg_write_e, mem_write_e);
    end
    instr_d = 32'h0000B293;  // I-ALU with funct3=011
    @(posedge clk); #1;
    vectors++;
    if (illegal_e !== 1'b1 || reg_write_e !== 1'b0) begin
      errors++; $display("FAIL illegal_funct3: ill=%b rw=%b want 1 0", illegal_e, reg_write_e);
    end
    instr_d = 32'h00402283; valid_d = 1'b0;  // lw as bubble
    @(posedge clk); #1;
    vectors++;
    if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || mem_write_e !== 1'b0 || illegal_e !== 1'b0) begin
      errors++; $display("FAIL bubble: v=%b rw=%b mw=%b ill=%b want 0 0 0 0", valid_e, reg_write_e, mem_write_e, illegal_e);
    end
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    instr_d = 32'h0000006F; valid_d = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; stall_d = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (get_obs() !== out_t'(0)) begin
      errors++; $display("FAIL reset_during_stall: got %h want 0", get_obs());
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    out_t exp_q, msk_q, e, m, o;
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13;
    ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h00;
    exp_q = '0; msk_q = '1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      instr_d = $urandom;
      instr_d[6:0] = ops[$urandom_range(0, 6)];
      if (instr_d[6:0] == 7'h00) instr_d[6:0] = 7'($urandom);
      pc_d = $urandom; pc_plus4_d = pc_d + 32'd4;
      valid_d = ($urandom_range(0, 4) != 0);
      stall_d = ($urandom_range(0, 5) == 0);
      flush_e = ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 49) == 0);
      rd1_rf = $urandom; rd2_rf = $urandom; result_w = $urandom;
      we_w = 1'($urandom);
      case ($urandom_range(0, 3))
        0: rd_w = instr_d[19:15];
        1: rd_w = instr_d[24:20];
        2: rd_w = 5'd0;
        default: rd_w = 5'($urandom);
      endcase
      #1;
      vectors++;
      if (a1_d !== instr_d[19:15] || a2_d !== instr_d[24:20]) begin
        errors++; $display("FAIL rand_addr %0d: a1=%0d a2=%0d want %0d %0d", n, a1_d, a2_d, instr_d[19:15], instr_d[24:20]);
      end
      model(instr_d, pc_d, pc_plus4_d, valid_d, rd1_rf, rd2_rf, we_w, rd_w, result_w, e, m);
      if (rst || flush_e) begin exp_q = '0; msk_q = '1; end
      else if (!stall_d) begin exp_q = e; msk_q = m; end
      @(posedge clk); #1;
      o = get_obs();
      vectors++;
      if ((o & msk_q) !== (exp_q & msk_q)) begin
        errors++; $display("FAIL rand_idex %0d instr=%h: got %h want %h", n, instr_d, o & msk_q, exp_q & msk_q);
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_addi();
    test_bypass();
    test_sub_beq();
    test_stall_flush();
    test_illegal();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
